// File: rtl/sprite_map_pkg.sv
// rtl/sprite_map_pkg.sv - shared types, tile codes and row-slice helper for the sprite map writer
package sprite_map_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD_CUR,
    S_WR_CUR,
    S_RD_NXT,
    S_WR_NXT,
    S_FIN
  } state_t;

  localparam logic [3:0] EMPTY_TILE_DEFAULT = 4'd0;
  localparam logic [3:0] TILE_WALL          = 4'd1;
  localparam logic [3:0] TILE_PILL          = 4'd2;
  localparam logic [3:0] TILE_PACMAN        = 4'd3;
  localparam logic [3:0] TILE_GHOST         = 4'd4;

  // Column 0 sits at the MSBs of a row word.
  function automatic int tile_lsb(input int x, input int rw, input int tw);
    return rw - tw * (x + 1);
  endfunction

endpackage

// File: rtl/sprite_map_writer_if.sv
// rtl/sprite_map_writer_if.sv - tile-map RAM port-B bundle
interface sprite_map_writer_if #(
  parameter int YW = 5,
  parameter int RW = 160
);
  logic [YW-1:0] addr;
  logic          wren;
  logic [RW-1:0] wrdata;
  logic [RW-1:0] rddata;

  modport master (output addr, output wren, output wrdata, input rddata);
  modport slave  (input addr, input wren, input wrdata, output rddata);
endinterface

// File: rtl/sprite_map_writer_rr_arbiter.sv
// rtl/sprite_map_writer_rr_arbiter.sv - round-robin arbiter, pointer advances past each accepted grant
module rr_arbiter #(
  parameter int N  = 3,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic          vld,
  output logic [CW-1:0] gnt
);

  logic [CW-1:0] ptr;

  always_comb begin
    int idx;
    idx = 0;
    vld = 1'b0;
    gnt = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!vld && req[idx]) begin
        vld = 1'b1;
        gnt = CW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en && vld) begin
      ptr <= (gnt == CW'(N - 1)) ? '0 : gnt + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_map_writer.sv
// rtl/sprite_map_writer.sv - multi-sprite read-modify-write engine for the tile-map RAM port B
module sprite_map_writer
  import sprite_map_pkg::*;
#(
  parameter int COLS    = 40,
  parameter int ROWS    = 30,
  parameter int TILE_W  = 4,
  parameter int NUM_SPR = 3,
  parameter int RD_LAT  = 2,
  parameter logic [TILE_W-1:0]  EMPTY_TILE   = TILE_W'(EMPTY_TILE_DEFAULT),
  parameter logic [NUM_SPR-1:0] RESTORE_MASK = NUM_SPR'('b110),
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS),
  localparam int RW = COLS * TILE_W
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [NUM_SPR-1:0]        req,
  input  logic [NUM_SPR*XW-1:0]     curr_x,
  input  logic [NUM_SPR*YW-1:0]     curr_y,
  input  logic [NUM_SPR*XW-1:0]     next_x,
  input  logic [NUM_SPR*YW-1:0]     next_y,
  input  logic [NUM_SPR*TILE_W-1:0] spr_code,
  output logic [NUM_SPR-1:0]        done,
  output logic                      err,
  output logic [TILE_W-1:0]         hit_tile,
  sprite_map_writer_if.master       ram
);

  localparam int CW  = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int LW  = $clog2(RW);
  localparam int CNW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  state_t            state;
  logic [CW-1:0]     ch;
  logic [CNW-1:0]    cnt;
  logic [XW-1:0]     lat_cx, lat_nx;
  logic [YW-1:0]     lat_cy, lat_ny;
  logic [TILE_W-1:0] lat_code;
  logic [TILE_W-1:0] under_tile [NUM_SPR];

  logic              arb_vld;
  logic [CW-1:0]     arb_gnt;

  logic [LW-1:0]     cur_lsb, nxt_lsb;
  logic [TILE_W-1:0] restore_tile, old_tile;
  logic [RW-1:0]     cur_row, nxt_row;
  logic              out_of_range, null_move, rd_ready;

  rr_arbiter #(.N(NUM_SPR), .CW(CW)) u_arb (
    .clk   (CLOCK_50),
    .reset (reset),
    .req   (req),
    .en    (state == S_IDLE),
    .vld   (arb_vld),
    .gnt   (arb_gnt)
  );

  always_comb begin
    cur_lsb      = LW'(tile_lsb(int'(lat_cx), RW, TILE_W));
    nxt_lsb      = LW'(tile_lsb(int'(lat_nx), RW, TILE_W));
    restore_tile = RESTORE_MASK[ch] ? under_tile[ch] : EMPTY_TILE;
    cur_row      = ram.rddata;
    cur_row[cur_lsb +: TILE_W] = restore_tile;
    nxt_row      = ram.rddata;
    nxt_row[nxt_lsb +: TILE_W] = lat_code;
    old_tile     = ram.rddata[nxt_lsb +: TILE_W];
    out_of_range = (int'(lat_cx) >= COLS) || (int'(lat_nx) >= COLS) ||
                   (int'(lat_cy) >= ROWS) || (int'(lat_ny) >= ROWS);
    null_move    = (lat_cx == lat_nx) && (lat_cy == lat_ny);
    rd_ready     = (cnt == CNW'(RD_LAT));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      done       <= '0;
      err        <= 1'b0;
      hit_tile   <= EMPTY_TILE;
      ram.wren   <= 1'b0;
      ram.addr   <= '0;
      ram.wrdata <= '0;
      cnt        <= '0;
      ch         <= '0;
      lat_cx     <= '0;
      lat_cy     <= '0;
      lat_nx     <= '0;
      lat_ny     <= '0;
      lat_code   <= '0;
      for (int i = 0; i < NUM_SPR; i++) under_tile[i] <= EMPTY_TILE;
    end else begin
      case (state)
        S_IDLE: begin
          done <= '0;
          err  <= 1'b0;
          if (arb_vld) begin
            ch       <= arb_gnt;
            lat_cx   <= curr_x[int'(arb_gnt)*XW +: XW];
            lat_cy   <= curr_y[int'(arb_gnt)*YW +: YW];
            lat_nx   <= next_x[int'(arb_gnt)*XW +: XW];
            lat_ny   <= next_y[int'(arb_gnt)*YW +: YW];
            lat_code <= spr_code[int'(arb_gnt)*TILE_W +: TILE_W];
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (out_of_range) begin
            err   <= 1'b1;
            done  <= NUM_SPR'(1) << ch;
            state <= S_FIN;
          end else if (null_move) begin
            hit_tile <= under_tile[ch];
            done     <= NUM_SPR'(1) << ch;
            state    <= S_FIN;
          end else begin
            ram.addr <= lat_cy;
            cnt      <= '0;
            state    <= S_RD_CUR;
          end
        end
        S_RD_CUR: begin
          if (rd_ready) begin
            ram.wren   <= 1'b1;
            ram.wrdata <= cur_row;
            state      <= S_WR_CUR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WR_CUR: begin
          // Write lands this edge, so the next-row read below sees it without forwarding.
          ram.wren <= 1'b0;
          ram.addr <= lat_ny;
          cnt      <= '0;
          state    <= S_RD_NXT;
        end
        S_RD_NXT: begin
          if (rd_ready) begin
            ram.wren       <= 1'b1;
            ram.wrdata     <= nxt_row;
            hit_tile       <= old_tile;
            under_tile[ch] <= old_tile;
            state          <= S_WR_NXT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WR_NXT: begin
          ram.wren <= 1'b0;
          err      <= 1'b0;
          done     <= NUM_SPR'(1) << ch;
          state    <= S_FIN;
        end
        S_FIN: begin
          done  <= '0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_map_writer.sv
// tb/tb_sprite_map_writer.sv - directed self-checking bench for sprite_map_writer
module tb_sprite_map_writer;
  import sprite_map_pkg::*;

  localparam int XW = 6;
  localparam int YW = 5;
  localparam int RW = 160;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req;
  logic [17:0]   curr_x, next_x;
  logic [14:0]   curr_y, next_y;
  logic [11:0]   spr_code;
  logic [2:0]    done;
  logic          err;
  logic [3:0]    hit_tile;

  sprite_map_writer_if #(.YW(YW), .RW(RW)) bus ();

  sprite_map_writer dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .req      (req),
    .curr_x   (curr_x),
    .curr_y   (curr_y),
    .next_x   (next_x),
    .next_y   (next_y),
    .spr_code (spr_code),
    .done     (done),
    .err      (err),
    .hit_tile (hit_tile),
    .ram      (bus)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] mem [32];
  logic [RW-1:0] rd_s1, rd_s2;
  logic          poke_we = 1'b0;
  logic [YW-1:0] poke_a  = '0;
  logic [RW-1:0] poke_d  = '0;
  int            wcnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (bus.wren) begin
      mem[bus.addr] <= bus.wrdata;
    end else if (poke_we) begin
      mem[poke_a] <= poke_d;
    end
    rd_s1 <= mem[bus.addr];
    rd_s2 <= rd_s1;
    if (bus.wren) wcnt++;
  end
  assign bus.rddata = rd_s2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] tget(input logic [RW-1:0] row, input int x);
    return row[156 - 4*x +: 4];
  endfunction

  function automatic logic [RW-1:0] tput(input logic [RW-1:0] row, input int x, input logic [3:0] v);
    logic [RW-1:0] r;
    r = row;
    r[156 - 4*x +: 4] = v;
    return r;
  endfunction

  task automatic poke(input int row, input logic [RW-1:0] d);
    poke_we = 1'b1;
    poke_a  = YW'(row);
    poke_d  = d;
    @(posedge clk);
    @(negedge clk);
    poke_we = 1'b0;
  endtask

  task automatic set_ch(input int c, input int cx, input int cy, input int nx, input int ny,
                        input logic [3:0] code);
    curr_x[c*XW +: XW]  = XW'(cx);
    curr_y[c*YW +: YW]  = YW'(cy);
    next_x[c*XW +: XW]  = XW'(nx);
    next_y[c*YW +: YW]  = YW'(ny);
    spr_code[c*4 +: 4]  = code;
  endtask

  // Called at a negedge with the FSM idle; lat counts edges including the grant edge.
  task automatic run_move(input int c, output int lat, output logic [3:0] hit,
                          output logic e, output int wr);
    bit got;
    got = 0;
    lat = 0;
    hit = 'x;
    e   = 'x;
    wcnt = 0;
    req[c] = 1'b1;
    while (!got && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done[c]) begin
        got    = 1;
        hit    = hit_tile;
        e      = err;
        req[c] = 1'b0;
      end
    end
    if (!got) check("move_timeout", 0, 1);
    wr = wcnt;
    @(negedge clk);
  endtask

  int            lat, wr;
  logic [3:0]    hit;
  logic          e;
  int            order[$];
  bit            seen;

  initial begin
    reset = 1'b1;
    req = '0; curr_x = '0; curr_y = '0; next_x = '0; next_y = '0; spr_code = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_hit", hit_tile, EMPTY_TILE_DEFAULT);
    check("rst_wren", bus.wren, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_wrdata", bus.wrdata, 0);
    reset = 1'b0;

    poke(3, tput(tput('0, 5, TILE_PACMAN), 6, TILE_PILL));
    poke(5, tput('0, 10, TILE_PILL));
    poke(6, tput('0, 10, TILE_WALL));

    // Pacman eats a pill: (5,3) -> (6,3)
    set_ch(0, 5, 3, 6, 3, TILE_PACMAN);
    run_move(0, lat, hit, e, wr);
    check("pac_grant_to_done", lat - 1, 9);
    check("pac_hit", hit, TILE_PILL);
    check("pac_err", e, 0);
    check("pac_writes", wr, 2);
    check("pac_old_cell", tget(mem[3], 5), 0);
    check("pac_new_cell", tget(mem[3], 6), TILE_PACMAN);

    // Pacman does not restore the pill it ate: (6,3) -> (7,3)
    set_ch(0, 6, 3, 7, 3, TILE_PACMAN);
    run_move(0, lat, hit, e, wr);
    check("pac2_hit", hit, 0);
    check("pac2_old_cell", tget(mem[3], 6), 0);
    check("pac2_new_cell", tget(mem[3], 7), TILE_PACMAN);

    // Ghost walks over a pill and puts it back
    set_ch(1, 10, 4, 10, 5, TILE_GHOST);
    run_move(1, lat, hit, e, wr);
    check("gh1_hit", hit, TILE_PILL);
    check("gh1_old_cell", tget(mem[4], 10), 0);
    check("gh1_new_cell", tget(mem[5], 10), TILE_GHOST);
    set_ch(1, 10, 5, 10, 6, TILE_GHOST);
    run_move(1, lat, hit, e, wr);
    check("gh2_hit", hit, TILE_WALL);
    check("gh2_writes", wr, 2);
    check("gh2_restored", tget(mem[5], 10), TILE_PILL);
    check("gh2_new_cell", tget(mem[6], 10), TILE_GHOST);

    // Null move reports the saved under-tile and writes nothing
    set_ch(1, 10, 6, 10, 6, TILE_GHOST);
    run_move(1, lat, hit, e, wr);
    check("null_hit", hit, TILE_WALL);
    check("null_err", e, 0);
    check("null_writes", wr, 0);

    // Column 40 is out of range
    set_ch(2, 0, 0, 40, 0, TILE_GHOST);
    run_move(2, lat, hit, e, wr);
    check("range_err", e, 1);
    check("range_writes", wr, 0);

    // Reset while in WR_CUR
    set_ch(0, 2, 8, 3, 8, TILE_PACMAN);
    req[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.wren) seen = 1;
    end
    check("abort_reached_wr", seen, 1);
    reset  = 1'b1;
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    check("abort_wren_low", bus.wren, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done != 0) seen = 1;
    end
    check("abort_no_done", seen, 0);

    set_ch(1, 7, 7, 7, 7, TILE_GHOST);
    run_move(1, lat, hit, e, wr);
    check("abort_under_cleared", hit, EMPTY_TILE_DEFAULT);

    poke(10, tput('0, 1, TILE_PILL));
    set_ch(0, 0, 10, 1, 10, TILE_PACMAN);
    run_move(0, lat, hit, e, wr);
    check("fresh_grant_to_done", lat - 1, 9);
    check("fresh_hit", hit, TILE_PILL);
    check("fresh_new_cell", tget(mem[10], 1), TILE_PACMAN);

    // Simultaneous requests from a fresh pointer
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_ch(0, 0, 0, 1, 0, TILE_PACMAN);
    set_ch(1, 0, 1, 1, 1, TILE_GHOST);
    set_ch(2, 0, 2, 1, 2, TILE_GHOST);
    order.delete();
    req = 3'b111;
    for (int i = 0; i < 100 && order.size() < 3; i++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (done[c]) begin
          order.push_back(c);
          req[c] = 1'b0;
        end
      end
    end
    check("cont_count", order.size(), 3);
    while (order.size() < 3) order.push_back(-1);
    check("cont_first", order[0], 0);
    check("cont_second", order[1], 1);
    check("cont_third", order[2], 2);
    @(negedge clk);

    // Held requests on ch1 and ch2 must alternate
    order.delete();
    req = 3'b110;
    for (int i = 0; i < 200 && order.size() < 4; i++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) if (done[c]) order.push_back(c);
    end
    req = '0;
    check("fair_count", order.size(), 4);
    while (order.size() < 4) order.push_back(-1);
    check("fair_0", order[0], 1);
    check("fair_1", order[1], 2);
    check("fair_2", order[2], 1);
    check("fair_3", order[3], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sprite_map_writer.md
Name: sprite_map_writer

Overview:
- Parametrised successor to the fixed pacman/two-ghost map RAM writer.
- Serves NUM_SPR sprite channels. Channel 0 is pacman; the rest are ghosts.
- For each move it does a read-modify-write of the tile-map RAM through one port (port B): erase the sprite at its current cell, then stamp it at its next cell.
- Per channel, it either restores the tile the sprite covered or leaves the cell empty (pill eating). It reports the tile that was overwritten, for collision logic.

Parameters:
- COLS, 40, tiles per map row. Row word width is COLS*TILE_W.
- ROWS, 30, map rows (RAM depth).
- TILE_W, 4, bits per tile code.
- NUM_SPR, 3, number of sprite channels.
- RD_LAT, 2, map RAM read latency in cycles, from address to valid rddata.
- EMPTY_TILE, 0, tile code written for an empty cell.
- RESTORE_MASK, 'b110, bit i=1: channel i restores the covered tile on erase; bit i=0: channel i writes EMPTY_TILE.
- Derived: XW=$clog2(COLS), YW=$clog2(ROWS), RW=COLS*TILE_W.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req  in  NUM_SPR  move request, one bit per channel; held high until done.
- curr_x  in  NUM_SPR*XW  current column, channel i at [i*XW +: XW].
- curr_y  in  NUM_SPR*YW  current row.
- next_x  in  NUM_SPR*XW  target column.
- next_y  in  NUM_SPR*YW  target row.
- spr_code  in  NUM_SPR*TILE_W  tile code to stamp for each channel.
- done  out  NUM_SPR  one-cycle completion pulse per channel.
- err  out  1  valid with done; 1 = request rejected (coordinate out of range).
- hit_tile  out  TILE_W  tile that was at the next cell before the stamp; valid with done.
- addr  out  YW  map RAM port-B row address.
- wren  out  1  port-B write enable.
- wrdata  out  RW  port-B write row.
- rddata  in  RW  port-B read row.

Behaviour:
- Tile x in a row occupies bits [RW-1-(TILE_W*x+TILE_W-1) +: TILE_W], so column 0 is at the MSBs.
- Reset values:
  - done=0, err=0, hit_tile=EMPTY_TILE, wren=0, addr=0, wrdata=0.
  - FSM=IDLE, round-robin pointer=0.
  - Every under_tile[i]=EMPTY_TILE.
- Arbitration: round-robin. Search starts at the channel after the last one granted. Grant happens only in IDLE. Inputs of the granted channel are latched at grant; later changes are ignored until its done.
- FSM states:
  - IDLE: if any req, grant and go to CHECK.
  - CHECK:
    - Any latched coordinate out of range (x>=COLS or y>=ROWS): go to FIN with err=1.
    - curr==next (both x and y): go to FIN with err=0, hit_tile=under_tile[ch], no RAM write.
    - Otherwise go to RD_CUR.
  - RD_CUR: addr=curr_y. Wait RD_LAT cycles (counter), then WR_CUR.
  - WR_CUR: wren=1 for one cycle, addr=curr_y, wrdata=rddata with tile curr_x replaced. The replacement is under_tile[ch] if RESTORE_MASK[ch]=1, else EMPTY_TILE.
  - RD_NXT: addr=next_y. Wait RD_LAT cycles. A read of the same row returns the row just written; this needs no forwarding because the write precedes the read address.
  - WR_NXT: wren=1, wrdata=rddata with tile next_x replaced by spr_code[ch]. The old tile is captured into hit_tile and into under_tile[ch].
  - FIN: done[ch]=1 for exactly one cycle, then IDLE.
- Latency of a normal move: 1 (CHECK) + (RD_LAT+1)*2 + 2 (RD_NXT setup, FIN) cycles from grant. With RD_LAT=2 that is 9 cycles from the IDLE grant to the done pulse.
- A requester must drop req in the cycle after done, otherwise it is re-granted when its round-robin turn comes.
- wren is asserted only in WR_CUR and WR_NXT, at most two write cycles per move.
- Simultaneous requests: served one at a time, in round-robin order. No request is starved: worst-case wait is (NUM_SPR-1) moves.
- If a sprite's next cell holds another sprite's code, that code is reported in hit_tile and saved as under_tile. Collision policy belongs to the consumer.
- Reset mid-operation: FSM returns to IDLE the next cycle, wren drops immediately, the pending move is abandoned with no done, and under_tiles are cleared.

Decomposition:
- Package sprite_map_pkg: FSM state enum, EMPTY_TILE default, tile-code constants (WALL, PILL, PACMAN, GHOST), and a function for the tile-slice bit offset.
- Sub-module rr_arbiter: NUM_SPR-wide round-robin arbiter with grant-on-enable and pointer update.

Test Plan:
- Pacman move: ch0, cur (5,3), next (6,3); row 3 tile 6 = PILL; RD_LAT=2 → two writes to row 3. After the second, tile 5=0 and tile 6=PACMAN code. hit_tile=PILL, done[0] 9 cycles after grant.
- Ghost restore: ch1 moves (10,4)→(10,5) over PILL, then (10,5)→(10,6). Second move writes PILL back at (10,5); under_tile[1]=tile previously at (10,6).
- Contention: req=3'b111 in the same cycle → done order ch0, ch1, ch2. Then with req held high, ch1 and ch2 both requesting → ch1 is never granted twice in a row.
- Range error: ch2 next_x=40 → err=1 with done[2], wren never asserted.
- Null move: curr==next → done with no wren; hit_tile=under_tile.
- Reset at WR_CUR: wren=0 the next cycle, no done pulse; a fresh request afterwards completes normally.
